// File: rtl/glip_traffic_gen_pkg.sv
// Shared mode encodings, FSM state type and mode-to-state decode for the GLIP
// traffic generator.
package glip_traffic_gen_pkg;

    localparam logic [1:0] MODE_LOOP   = 2'b00;
    localparam logic [1:0] MODE_SRC    = 2'b01;
    localparam logic [1:0] MODE_SNK    = 2'b10;
    localparam logic [1:0] MODE_DUPLEX = 2'b11;

    typedef enum logic [2:0] {
        ST_LOOP,
        ST_SRC,
        ST_SNK,
        ST_DUPLEX,
        ST_SWITCH
    } state_e;

    function automatic state_e mode_to_state(input logic [1:0] m);
        case (m)
            MODE_LOOP: return ST_LOOP;
            MODE_SRC:  return ST_SRC;
            MODE_SNK:  return ST_SNK;
            default:   return ST_DUPLEX;
        endcase
    endfunction

endpackage

// File: rtl/glip_traffic_gen_if.sv
// GLIP logic-side FIFO stream pair: backend-to-logic (in_*) and logic-to-backend
// (out_*). The slave modport is the traffic generator side.
interface glip_traffic_gen_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/glip_traffic_check.sv
// Sink sequence checker: expects each accepted word to be the previous one plus
// one, resyncing on the first word after a resync pulse; saturating error count.
module glip_traffic_check #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 resync_i,
    input  logic                 clear_i,
    input  logic                 valid_i,
    input  logic [WIDTH-1:0]     data_i,
    output logic [CNT_WIDTH-1:0] error_count_o,
    output logic                 error_o
);
    logic                 synced_q;
    logic [WIDTH-1:0]     exp_q;
    logic [CNT_WIDTH-1:0] err_cnt_q;
    logic                 error_q;
    logic                 mismatch;

    assign mismatch      = valid_i & synced_q & (data_i != exp_q);
    assign error_count_o = err_cnt_q;
    assign error_o       = error_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            synced_q  <= 1'b0;
            exp_q     <= '0;
            err_cnt_q <= '0;
            error_q   <= 1'b0;
        end else begin
            // On a match data_i+1 equals exp_q+1, so one assignment covers sync, match and resync.
            if (resync_i) begin
                synced_q <= 1'b0;
            end else if (valid_i) begin
                synced_q <= 1'b1;
                exp_q    <= data_i + WIDTH'(1);
            end
            if (clear_i) begin
                err_cnt_q <= '0;
                error_q   <= 1'b0;
            end else if (mismatch) begin
                if (err_cnt_q != '1) begin
                    err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
                end
                error_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/glip_traffic_gen.sv
// GLIP traffic generator/checker: loopback, counting source, checked sink and
// duplex modes with saturating statistics. Checker built when GLIP_TRAFFIC_GEN_CHECK_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_SWITCH | one idle cycle between modes; clears source, resyncs checker
// ST_LOOP   | in stream passed combinationally to out stream
// ST_SRC    | out stream carries incrementing source counter
// ST_SNK    | in stream consumed and fed to the checker
// ST_DUPLEX | source and sink active together
module glip_traffic_gen
    import glip_traffic_gen_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [1:0]           mode,
    input  logic                 sink_stall,
    input  logic                 clear,
    glip_traffic_gen_if.slave    fifo,
    output logic [CNT_WIDTH-1:0] xfer_count,
    output logic [CNT_WIDTH-1:0] error_count,
    output logic                 error
);
    state_e               state_q;
    logic [1:0]           mode_q;
    logic                 loop_en_q;
    logic                 src_en_q;
    logic                 snk_en_q;
    logic [WIDTH-1:0]     src_cnt_q, src_cnt_d;
    logic [CNT_WIDTH-1:0] xfer_q, xfer_d;
    logic [CNT_WIDTH:0]   xfer_sum;
    logic [1:0]           xfer_inc;
    logic                 out_valid;
    logic                 in_ready;
    logic                 out_hs;
    logic                 in_hs;
    logic                 switch_ok;

    assign out_valid = loop_en_q ? fifo.in_valid : src_en_q;
    assign in_ready  = loop_en_q ? fifo.out_ready : (snk_en_q & ~sink_stall);
    assign out_hs    = out_valid & fifo.out_ready;
    assign in_hs     = fifo.in_valid & in_ready;
    // A pending beat must complete before the mode may change.
    assign switch_ok = ~out_valid | fifo.out_ready;

    assign fifo.out_valid = out_valid;
    assign fifo.in_ready  = in_ready;
    assign fifo.out_data  = loop_en_q ? fifo.in_data : (src_en_q ? src_cnt_q : '0);
    assign xfer_count     = xfer_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_SWITCH;
            mode_q    <= MODE_LOOP;
            loop_en_q <= 1'b0;
            src_en_q  <= 1'b0;
            snk_en_q  <= 1'b0;
        end else if (state_q == ST_SWITCH) begin
            state_q   <= mode_to_state(mode);
            mode_q    <= mode;
            loop_en_q <= (mode == MODE_LOOP);
            src_en_q  <= (mode == MODE_SRC) || (mode == MODE_DUPLEX);
            snk_en_q  <= (mode == MODE_SNK) || (mode == MODE_DUPLEX);
        end else if ((mode != mode_q) && switch_ok) begin
            state_q   <= ST_SWITCH;
            loop_en_q <= 1'b0;
            src_en_q  <= 1'b0;
            snk_en_q  <= 1'b0;
        end
    end

    always_comb begin
        src_cnt_d = src_cnt_q;
        if (state_q == ST_SWITCH) begin
            src_cnt_d = '0;
        end else if (src_en_q && fifo.out_ready) begin
            src_cnt_d = src_cnt_q + WIDTH'(1);
        end
    end

    // In loopback both handshakes are the same transfer, so count it once.
    always_comb begin
        xfer_inc = loop_en_q ? {1'b0, out_hs} : ({1'b0, out_hs} + {1'b0, in_hs});
        xfer_sum = {1'b0, xfer_q} + (CNT_WIDTH + 1)'(xfer_inc);
        if (clear) begin
            xfer_d = '0;
        end else if (xfer_sum[CNT_WIDTH]) begin
            xfer_d = '1;
        end else begin
            xfer_d = xfer_sum[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            src_cnt_q <= '0;
            xfer_q    <= '0;
        end else begin
            src_cnt_q <= src_cnt_d;
            xfer_q    <= xfer_d;
        end
    end

`ifdef GLIP_TRAFFIC_GEN_CHECK_EN
    glip_traffic_check #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_check (
        .clk           (clk),
        .rstn          (rstn),
        .resync_i      (state_q == ST_SWITCH),
        .clear_i       (clear),
        .valid_i       (in_hs & ~loop_en_q),
        .data_i        (fifo.in_data),
        .error_count_o (error_count),
        .error_o       (error)
    );
`else
    assign error_count = '0;
    assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_glip_traffic_gen.sv
// Directed bench for glip_traffic_gen: a 32-bit-counter instance and a 4-bit-counter
// instance share one stimulus stream; cycle table plus hand-written corner sequences.
module tb_glip_traffic_gen;

`ifdef GLIP_TRAFFIC_GEN_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  mode;
    logic        sink_stall;
    logic        clear;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_data;

    logic [31:0] xfer, errc;
    logic        err;
    logic [3:0]  xfer_s, errc_s;
    logic        err_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    glip_traffic_gen_if #(.WIDTH(16)) fa ();
    glip_traffic_gen_if #(.WIDTH(16)) fb ();

    assign fa.in_data   = in_data;
    assign fa.in_valid  = in_valid;
    assign fa.out_ready = out_ready;
    assign fb.in_data   = in_data;
    assign fb.in_valid  = in_valid;
    assign fb.out_ready = out_ready;

    glip_traffic_gen #(.WIDTH(16), .CNT_WIDTH(32)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .mode        (mode),
        .sink_stall  (sink_stall),
        .clear       (clear),
        .fifo        (fa),
        .xfer_count  (xfer),
        .error_count (errc),
        .error       (err)
    );

    glip_traffic_gen #(.WIDTH(16), .CNT_WIDTH(4)) dut_sat (
        .clk         (clk),
        .rstn        (rstn),
        .mode        (mode),
        .sink_stall  (sink_stall),
        .clear       (clear),
        .fifo        (fb),
        .xfer_count  (xfer_s),
        .error_count (errc_s),
        .error       (err_s)
    );

    typedef struct {
        logic [1:0]  mode;
        logic        iv;
        logic [15:0] id;
        logic        ordy;
        logic        stall;
        logic        clr;
        logic        ov;
        logic [15:0] od;
        logic        ir;
        int unsigned xf;
        logic        ef;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic add(input logic [1:0] m, input logic iv, input logic [15:0] id,
                       input logic ordy, input logic st, input logic cl,
                       input logic ov, input logic [15:0] od, input logic ir,
                       input int unsigned xf, input logic ef);
        vec_t v;
        v.mode = m;  v.iv = iv;  v.id = id;  v.ordy = ordy; v.stall = st; v.clr = cl;
        v.ov = ov;   v.od = od;  v.ir = ir;  v.xf = xf;     v.ef = ef;
        vq.push_back(v);
    endtask

    function automatic logic [31:0] sat4(input int unsigned x);
        return (x > 15) ? 32'd15 : x;
    endfunction

    initial begin
        //   mode iv  id       rdy st cl   ov od       ir xf  ef
        add(2'd0, 1, 16'h1234, 0, 0, 0,   0, 16'h0000, 0, 0,  0); // SWITCH after reset
        add(2'd0, 1, 16'h1234, 0, 0, 0,   1, 16'h1234, 0, 0,  0); // LOOP, backpressure
        add(2'd0, 1, 16'hABCD, 1, 0, 0,   1, 16'hABCD, 1, 0,  0);
        add(2'd0, 1, 16'h0001, 1, 0, 0,   1, 16'h0001, 1, 1,  0);
        add(2'd0, 0, 16'h0002, 1, 0, 0,   0, 16'h0002, 1, 2,  0);
        add(2'd0, 1, 16'h0007, 0, 0, 0,   1, 16'h0007, 0, 2,  0);
        add(2'd1, 1, 16'h0007, 0, 0, 0,   1, 16'h0007, 0, 2,  0); // change held off
        add(2'd1, 1, 16'h0008, 1, 0, 0,   1, 16'h0008, 1, 2,  0);
        add(2'd1, 0, 16'h0000, 1, 0, 0,   0, 16'h0000, 0, 3,  0); // SWITCH
        add(2'd1, 0, 16'h0000, 1, 0, 0,   1, 16'h0000, 0, 3,  0); // SRC
        add(2'd1, 0, 16'h0000, 1, 0, 0,   1, 16'h0001, 0, 4,  0);
        add(2'd1, 0, 16'h0000, 1, 0, 0,   1, 16'h0002, 0, 5,  0);
        add(2'd1, 0, 16'h0000, 0, 0, 0,   1, 16'h0003, 0, 6,  0); // ready 0,0,1
        add(2'd1, 0, 16'h0000, 0, 0, 0,   1, 16'h0003, 0, 6,  0);
        add(2'd1, 0, 16'h0000, 1, 0, 0,   1, 16'h0003, 0, 6,  0);
        add(2'd1, 0, 16'h0000, 1, 0, 0,   1, 16'h0004, 0, 7,  0);
        add(2'd2, 0, 16'h0000, 0, 0, 0,   1, 16'h0005, 0, 8,  0); // SRC->SNK pending
        add(2'd2, 0, 16'h0000, 0, 0, 0,   1, 16'h0005, 0, 8,  0);
        add(2'd2, 0, 16'h0000, 1, 0, 0,   1, 16'h0005, 0, 8,  0);
        add(2'd2, 1, 16'h0005, 1, 0, 0,   0, 16'h0000, 0, 9,  0); // SWITCH
        add(2'd2, 1, 16'h0005, 1, 0, 0,   0, 16'h0000, 1, 9,  0); // SNK sync on 5
        add(2'd2, 1, 16'h0006, 1, 0, 0,   0, 16'h0000, 1, 10, 0);
        add(2'd2, 1, 16'h0007, 1, 0, 0,   0, 16'h0000, 1, 11, 0);
        add(2'd2, 1, 16'h0009, 1, 0, 0,   0, 16'h0000, 1, 12, 0); // mismatch
        add(2'd2, 1, 16'h000A, 1, 0, 0,   0, 16'h0000, 1, 13, 1);
        add(2'd2, 1, 16'h000B, 1, 1, 0,   0, 16'h0000, 0, 14, 1); // stall
        add(2'd2, 0, 16'h0000, 1, 0, 0,   0, 16'h0000, 1, 14, 1);
        add(2'd3, 0, 16'h0000, 1, 0, 0,   0, 16'h0000, 1, 14, 1);
        add(2'd3, 1, 16'h0020, 1, 0, 0,   0, 16'h0000, 0, 14, 1); // SWITCH
        add(2'd3, 1, 16'h0020, 1, 0, 0,   1, 16'h0000, 1, 14, 1); // DUPLEX, both
        add(2'd3, 1, 16'h0021, 1, 0, 0,   1, 16'h0001, 1, 16, 1);
        add(2'd3, 0, 16'h0000, 1, 0, 0,   1, 16'h0002, 1, 18, 1);
        add(2'd3, 1, 16'h0022, 0, 0, 0,   1, 16'h0003, 1, 19, 1);
        add(2'd3, 1, 16'h0023, 0, 1, 0,   1, 16'h0003, 0, 20, 1);
        add(2'd3, 0, 16'h0000, 0, 0, 1,   1, 16'h0003, 1, 20, 1); // clear
        add(2'd3, 0, 16'h0000, 0, 0, 0,   1, 16'h0003, 1, 0,  0);

        rstn = 1'b0; mode = 2'd0; sink_stall = 1'b0; clear = 1'b0;
        in_valid = 1'b1; in_data = 16'h5555; out_ready = 1'b1;
        tick(); tick(); tick();
        #1;
        chk("reset out_valid", {31'd0, fa.out_valid}, 32'd0);
        chk("reset in_ready",  {31'd0, fa.in_ready},  32'd0);
        chk("reset out_data",  {16'd0, fa.out_data},  32'd0);
        chk("reset xfer",      xfer, 32'd0);
        chk("reset err_cnt",   errc, 32'd0);
        chk("reset error",     {31'd0, err}, 32'd0);
        chk("reset sat out_valid", {31'd0, fb.out_valid}, 32'd0);
        rstn = 1'b1;

        foreach (vq[k]) begin
            mode = vq[k].mode; in_valid = vq[k].iv; in_data = vq[k].id;
            out_ready = vq[k].ordy; sink_stall = vq[k].stall; clear = vq[k].clr;
            #1;
            chk($sformatf("v%0d out_valid", k), {31'd0, fa.out_valid}, {31'd0, vq[k].ov});
            chk($sformatf("v%0d out_data", k),  {16'd0, fa.out_data},  {16'd0, vq[k].od});
            chk($sformatf("v%0d in_ready", k),  {31'd0, fa.in_ready},  {31'd0, vq[k].ir});
            chk($sformatf("v%0d xfer", k),      xfer, vq[k].xf);
            chk($sformatf("v%0d xfer_sat", k),  {28'd0, xfer_s}, sat4(vq[k].xf));
            chk($sformatf("v%0d err_cnt", k),   errc, {31'd0, vq[k].ef & CHK});
            chk($sformatf("v%0d error", k),     {31'd0, err}, {31'd0, vq[k].ef & CHK});
            chk($sformatf("v%0d sat error", k), {31'd0, err_s}, {31'd0, vq[k].ef & CHK});
            tick();
        end

        // DUPLEX, both handshakes plus clear in the same cycle: clear wins
        in_valid = 1'b1; in_data = 16'h0023; out_ready = 1'b1; clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_data = 16'h0024 + 16'(i);
            #1;
            chk($sformatf("dup%0d xfer", i), xfer, 32'(2 * i));
            chk($sformatf("dup%0d xfer_sat", i), {28'd0, xfer_s}, sat4(2 * i));
            chk($sformatf("dup%0d out_data", i), {16'd0, fa.out_data}, 32'(4 + i));
            tick();
        end
        #1;
        chk("dup xfer final", xfer, 32'd16);
        chk("dup xfer_sat final", {28'd0, xfer_s}, 32'd15);
        chk("dup err_cnt", errc, 32'd0);

        // SRC from count 0 across the 16-bit wrap
        mode = 2'd1; in_valid = 1'b0; out_ready = 1'b1; clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
        chk("wrap switch out_valid", {31'd0, fa.out_valid}, 32'd0);
        chk("wrap switch xfer", xfer, 32'd0);
        tick();
        for (int i = 0; i < 65538; i++) begin
            logic [15:0] e;
            e = 16'(i);
            #1;
            chk($sformatf("wrap%0d out_data", i), {16'd0, fa.out_data}, {16'd0, e});
            chk($sformatf("wrap%0d xfer", i), xfer, 32'(i));
            if (i == 65535 || i == 65536)
                chk($sformatf("wrap%0d out_valid", i), {31'd0, fa.out_valid}, 32'd1);
            tick();
        end
        #1;
        chk("wrap xfer_sat", {28'd0, xfer_s}, 32'd15);

        // reset while a SRC beat is pending
        out_ready = 1'b0;
        tick();
        #1;
        chk("hold out_data", {16'd0, fa.out_data}, 32'd2);
        chk("hold out_valid", {31'd0, fa.out_valid}, 32'd1);
        rstn = 1'b0;
        tick();
        #1;
        chk("midrst out_valid", {31'd0, fa.out_valid}, 32'd0);
        chk("midrst out_data", {16'd0, fa.out_data}, 32'd0);
        chk("midrst in_ready", {31'd0, fa.in_ready}, 32'd0);
        chk("midrst xfer", xfer, 32'd0);
        rstn = 1'b1; out_ready = 1'b1;
        #1;
        chk("postrst switch out_valid", {31'd0, fa.out_valid}, 32'd0);
        tick();
        #1;
        chk("postrst first beat valid", {31'd0, fa.out_valid}, 32'd1);
        chk("postrst first beat data", {16'd0, fa.out_data}, 32'd0);
        tick();
        #1;
        chk("postrst second beat data", {16'd0, fa.out_data}, 32'd1);
        chk("postrst xfer", xfer, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/glip_traffic_gen.md
# glip_traffic_gen

Parametrised traffic generator and checker for the GLIP logic-side FIFO interface. It replaces hard-wired board-demo stream muxing with four run-time modes: loopback, pattern source, checked sink, and full-duplex source plus sink. It also keeps saturating transfer and error statistics. It sits between any GLIP backend toplevel (UART, USB, ...) and the demo display/measurement logic.

## Interface
Parameters:
- WIDTH, 16: FIFO data width in bits; also the width of the pattern counter.
- CNT_WIDTH, 32: width of the `xfer_count` and `error_count` statistics counters.

Ports:
- clk  in  1  single clock for the whole block.
- rstn  in  1  reset, synchronous, active-low.
- mode  in  2  requested mode: 00 LOOP, 01 SRC, 10 SNK, 11 DUPLEX.
- sink_stall  in  1  when high, forces `in_ready` low in SNK and DUPLEX.
- clear  in  1  synchronous clear of the statistics counters and the sticky error flag.
- in_data  in  WIDTH  data from the backend; in_valid  in  1; in_ready  out  1.
- out_data  out  WIDTH  data to the backend; out_valid  out  1; out_ready  in  1.
- xfer_count  out  CNT_WIDTH  number of handshakes, saturating.
- error_count  out  CNT_WIDTH  number of sink sequence mismatches, saturating.
- error  out  1  sticky; set on the first mismatch.

## Operation
- State machine states: LOOP, SRC, SNK, DUPLEX, SWITCH. Reset enters SWITCH, which then targets `mode`.
- The registered mode (`mode_q`) is compared with `mode` every cycle. On a difference, the FSM enters SWITCH, but only when no output beat is pending: `out_valid` low, or `out_valid & out_ready` in that cycle. Otherwise the change waits.
- SWITCH lasts exactly 1 cycle:
  - `in_ready` and `out_valid` are low;
  - the source counter clears to 0 and the checker re-enters sync;
  - the next state is the one selected by `mode` as sampled in SWITCH.
- LOOP:
  - `out_data = in_data`, `out_valid = in_valid`, `in_ready = out_ready`, all combinational;
  - `xfer_count` increments on `out_valid & out_ready`.
- SRC:
  - `out_valid = 1`, `out_data = src_cnt`, `in_ready = 0`;
  - `src_cnt` increments by 1 per handshake and wraps from 2^WIDTH-1 to 0;
  - `xfer_count` increments per handshake.
- SNK:
  - `in_ready = ~sink_stall`, `out_valid = 0`, `out_data = 0`;
  - every accepted word increments `xfer_count` and goes to the checker.
- DUPLEX:
  - source and sink operate simultaneously;
  - `xfer_count` adds 0, 1 or 2 per cycle, one for each handshake that completes.
- Statistics counters saturate at 2^CNT_WIDTH-1 and never wrap.
- `clear` has priority over any increment in the same cycle.
- `clear` does not affect `src_cnt`, the checker, or the FSM.

## Timing
- Reset values (rstn low at a clk edge):
  - FSM in SWITCH;
  - `out_valid = 0`, `in_ready = 0`, `out_data = 0`;
  - `src_cnt = 0`;
  - `xfer_count = 0`, `error_count = 0`, `error = 0`.
- Reset mid-burst abandons the pending beat. The first beat after reset carries the value 0.
- LOOP path latency is 0 cycles. All other outputs come from registers.
- A SRC/DUPLEX beat holds `out_data` stable until `out_ready` is high. `out_valid` never drops without a handshake, except on reset.
- A mode change is observed 2 edges after `mode` changes with no beat pending: one edge to enter SWITCH, one to leave it.
- A statistics update is visible 1 cycle after the handshake that caused it.

## Configuration
- `GLIP_TRAFFIC_GEN_CHECK_EN` defined — the sequence checker is present:
  - on the first accepted word after SWITCH, `exp = in_data + 1` and no error is raised;
  - on each later word, if `in_data != exp`, then `error_count` increments, `error` sets, and `exp` resyncs to `in_data + 1`;
  - otherwise `exp` increments (mod 2^WIDTH).
- Macro undefined: no checker logic; `error_count` is tied to 0 and `error` is tied to 0. All other behaviour is unchanged.

## Structure
- Package `glip_traffic_gen_pkg` holds:
  - the mode encoding constants (MODE_LOOP, MODE_SRC, MODE_SNK, MODE_DUPLEX);
  - the FSM state enum, including SWITCH.
- One sub-module, `glip_traffic_check`: the checker plus the saturating error counter. It is instantiated only under the macro.

## Test plan
- Reset, then mode=01, out_ready=1 constantly, WIDTH=16 → after SWITCH, out_data is 0,1,2,… on consecutive cycles; 0xFFFF is followed by 0x0000; xfer_count tracks the number of beats.
- SRC with out_ready toggling 1,0,0,1 → out_data is held at the same value during the 0 cycles; no value is skipped or repeated.
- mode=10, in_data sequence 5,6,7,9,10 with the macro enabled → no error on 5 (sync); one error at 9; error_count=1; error=1; 10 is accepted with no further error.
- LOOP with in_valid=1, out_ready=0, then 1 → in_ready follows out_ready in the same cycle; out_data equals in_data; xfer_count increments only when out_ready=1.
- Mode change 01→10 requested while out_ready=0 → the FSM stays in SRC until a handshake, then spends one SWITCH cycle with both valid and ready low, then enters SNK.
- xfer_count preset near 2^CNT_WIDTH-1 (CNT_WIDTH=4) in DUPLEX with both handshakes every cycle → the counter saturates at 15; asserting clear in the same cycle yields 0.
